// File: rtl/fifo_rd_drain.sv
// Read-side drain controller: pops one FIFO word at a time and hands it to a
// serial transmitter over a valid/busy handshake, re-issuing unacknowledged hand-offs.
module fifo_rd_drain #(
  parameter int D_WIDTH = 8,
  parameter int C_WIDTH = 16,
  parameter int T_WIDTH = 4
) (
  input  logic               r_clk,
  input  logic               r_rst,
  input  logic               empty,
  input  logic [D_WIDTH-1:0] rd_data,
  output logic               r_inc,
  input  logic               tx_busy,
  output logic [D_WIDTH-1:0] tx_data,
  output logic               tx_valid,
  output logic [C_WIDTH-1:0] tx_count,
  output logic               tx_retry
);

  // state     | meaning
  // IDLE      | waiting for a word and an idle transmitter
  // LOAD      | settle cycle after the pop
  // SEND      | tx_valid asserted, timeout cleared
  // WAIT_ACK  | waiting for tx_busy, counting toward timeout
  // WAIT_DONE | transmitter busy with the word
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND, S_WAIT_ACK, S_WAIT_DONE
  } state_t;

  // Terminal value is one below all-ones, so WAIT_ACK lasts 2^T_WIDTH-1 cycles.
  localparam logic [T_WIDTH-1:0] TO_TERM = {{(T_WIDTH-1){1'b1}}, 1'b0};

  state_t             state_q, state_d;
  logic [D_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [C_WIDTH-1:0] count_q, count_d;
  logic [T_WIDTH-1:0] timeout_q, timeout_d;
  logic               valid_q, valid_d;
  logic               retry_q, retry_d;
  logic               pop;

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    count_d   = count_q;
    timeout_d = timeout_q;
    valid_d   = 1'b0;
    retry_d   = 1'b0;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && !tx_busy) begin
          pop       = 1'b1;
          tx_data_d = rd_data;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        valid_d = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        timeout_d = '0;
        state_d   = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // An acknowledge in the terminal cycle takes priority over the retry.
        if (tx_busy) begin
          count_d = count_q + C_WIDTH'(1);
          state_d = S_WAIT_DONE;
        end else if (timeout_q == TO_TERM) begin
          valid_d = 1'b1;
          retry_d = 1'b1;
          state_d = S_SEND;
        end else begin
          timeout_d = timeout_q + T_WIDTH'(1);
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state_q   <= S_IDLE;
      tx_data_q <= '0;
      count_q   <= '0;
      timeout_q <= '0;
      valid_q   <= 1'b0;
      retry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
      valid_q   <= valid_d;
      retry_q   <= retry_d;
    end
  end

  assign r_inc    = pop;
  assign tx_data  = tx_data_q;
  assign tx_valid = valid_q;
  assign tx_count = count_q;
  assign tx_retry = retry_q;

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: directed vector table, hand-built corner sequences and
// a randomized FIFO/transmitter run checked against a cycle-time rule model.
module tb_fifo_rd_drain;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int TW = 4;
  localparam int TO = (1 << TW) - 1;

  logic          r_clk = 1'b0;
  logic          r_rst, empty, tx_busy;
  logic [DW-1:0] rd_data;
  logic          r_inc, tx_valid, tx_retry;
  logic [DW-1:0] tx_data;
  logic [CW-1:0] tx_count;

  always #5 r_clk = ~r_clk;

  fifo_rd_drain #(.D_WIDTH(DW), .C_WIDTH(CW), .T_WIDTH(TW)) dut (
    .r_clk(r_clk), .r_rst(r_rst), .empty(empty), .rd_data(rd_data), .r_inc(r_inc),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_valid(tx_valid), .tx_count(tx_count),
    .tx_retry(tx_retry)
  );

  typedef struct {
    bit rst; bit emp; bit busy; logic [DW-1:0] d;
    bit rinc; bit valid; bit retry; logic [DW-1:0] data; logic [CW-1:0] cnt;
  } vec_t;

  int vectors = 0, miscompares = 0, cyc = 0;
  bit chk_en = 0;

  // Reference model: a transfer is described by the absolute cycle of its
  // tx_valid; the acknowledge window is the TO cycles that follow it.
  bit            m_xfer = 0, m_acked = 0, m_retry = 0;
  int            m_send_at = 0, m_count = 0;
  logic [DW-1:0] m_data = '0;
  bit            last_e_rinc, last_e_valid;

  int n_rinc = 0, n_valid = 0, n_retry = 0, last_retry_cyc = -1, last_rinc_cyc = -100;
  logic [DW-1:0] last_valid_data;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic cycle(input vec_t v, input bit use_tbl);
    bit e_rinc, e_valid, e_retry;
    r_rst = v.rst; empty = v.emp; tx_busy = v.busy; rd_data = v.d;
    @(negedge r_clk);
    e_rinc  = !m_xfer && !v.emp && !v.busy;
    e_valid = m_xfer && !m_acked && (cyc == m_send_at);
    e_retry = e_valid && m_retry;
    if (chk_en) begin
      vectors++;
      chk("r_inc", 32'(r_inc), 32'(e_rinc));
      chk("tx_valid", 32'(tx_valid), 32'(e_valid));
      chk("tx_retry", 32'(tx_retry), 32'(e_retry));
      chk("tx_data", 32'(tx_data), 32'(m_data));
      chk("tx_count", 32'(tx_count), 32'(m_count));
      if (use_tbl) begin
        chk("tbl_r_inc", 32'(r_inc), 32'(v.rinc));
        chk("tbl_tx_valid", 32'(tx_valid), 32'(v.valid));
        chk("tbl_tx_retry", 32'(tx_retry), 32'(v.retry));
        chk("tbl_tx_data", 32'(tx_data), 32'(v.data));
        chk("tbl_tx_count", 32'(tx_count), 32'(v.cnt));
      end
      if (r_inc === 1'b1) begin
        n_rinc++;
        if (cyc - last_rinc_cyc < 4) chk("r_inc_spacing", 32'(cyc - last_rinc_cyc), 32'd4);
        last_rinc_cyc = cyc;
      end
      if (tx_valid === 1'b1) begin n_valid++; last_valid_data = tx_data; end
      if (tx_retry === 1'b1) begin n_retry++; last_retry_cyc = cyc; end
    end
    last_e_rinc  = e_rinc;
    last_e_valid = e_valid;
    @(posedge r_clk);
    if (v.rst) begin
      m_xfer = 0; m_acked = 0; m_retry = 0; m_data = '0; m_count = 0;
    end else if (!m_xfer) begin
      if (e_rinc) begin
        m_xfer = 1; m_acked = 0; m_retry = 0; m_send_at = cyc + 2; m_data = v.d;
      end
    end else if (!m_acked) begin
      if (cyc > m_send_at) begin
        if (v.busy) begin
          m_acked = 1; m_count = (m_count + 1) % (1 << CW);
        end else if (cyc == m_send_at + TO) begin
          m_send_at = cyc + 1; m_retry = 1;
        end
      end
    end else if (!v.busy) begin
      m_xfer = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic drive(input bit rst, input bit emp, input bit busy, input logic [DW-1:0] d);
    vec_t v;
    v = '{rst, emp, busy, d, 1'b0, 1'b0, 1'b0, '0, '0};
    cycle(v, 1'b0);
  endtask

  task automatic xfer_word(input logic [DW-1:0] d);
    drive(0, 0, 0, d);
    drive(0, 1, 0, '0);
    drive(0, 1, 0, '0);
    drive(0, 1, 1, '0);
    drive(0, 1, 0, '0);
  endtask

  vec_t tbl[20];
  logic [DW-1:0] q[$];
  logic [DW-1:0] stale;

  initial begin
    int c0, nr, nv, nt;
    bit pop1, pop2, emp_eff, busy_r;
    int rise_at, fall_at, c;
    logic [DW-1:0] dat;

    //          rst emp bsy d      rinc val rty data   cnt
    tbl[0]  = '{0, 1, 0, 8'h00,   0, 0, 0, 8'h00, 4'd0};
    tbl[1]  = '{0, 0, 0, 8'hA5,   1, 0, 0, 8'h00, 4'd0};
    tbl[2]  = '{0, 1, 0, 8'h00,   0, 0, 0, 8'hA5, 4'd0};
    tbl[3]  = '{0, 1, 0, 8'h00,   0, 1, 0, 8'hA5, 4'd0};
    tbl[4]  = '{0, 1, 1, 8'h00,   0, 0, 0, 8'hA5, 4'd0};
    tbl[5]  = '{0, 1, 1, 8'h00,   0, 0, 0, 8'hA5, 4'd1};
    tbl[6]  = '{0, 1, 1, 8'h00,   0, 0, 0, 8'hA5, 4'd1};
    tbl[7]  = '{0, 1, 0, 8'h00,   0, 0, 0, 8'hA5, 4'd1};
    tbl[8]  = '{0, 0, 0, 8'h3C,   1, 0, 0, 8'hA5, 4'd1};
    tbl[9]  = '{0, 1, 0, 8'h00,   0, 0, 0, 8'h3C, 4'd1};
    tbl[10] = '{0, 1, 1, 8'h00,   0, 1, 0, 8'h3C, 4'd1};
    tbl[11] = '{0, 1, 1, 8'h00,   0, 0, 0, 8'h3C, 4'd1};
    tbl[12] = '{0, 1, 0, 8'h00,   0, 0, 0, 8'h3C, 4'd2};
    tbl[13] = '{0, 0, 1, 8'hFF,   0, 0, 0, 8'h3C, 4'd2};
    tbl[14] = '{0, 0, 0, 8'hFF,   1, 0, 0, 8'h3C, 4'd2};
    tbl[15] = '{0, 1, 0, 8'h00,   0, 0, 0, 8'hFF, 4'd2};
    tbl[16] = '{0, 1, 0, 8'h00,   0, 1, 0, 8'hFF, 4'd2};
    tbl[17] = '{0, 1, 1, 8'h00,   0, 0, 0, 8'hFF, 4'd2};
    tbl[18] = '{0, 1, 0, 8'h00,   0, 0, 0, 8'hFF, 4'd3};
    tbl[19] = '{0, 1, 0, 8'h00,   0, 0, 0, 8'hFF, 4'd3};

    drive(1, 1, 0, '0);
    drive(1, 1, 0, '0);
    chk_en = 1;
    drive(1, 1, 0, '0);
    for (int i = 0; i < 20; i++) cycle(tbl[i], 1'b1);
    chk("three_words_rinc", 32'(n_rinc), 32'd3);
    chk("three_words_retry", 32'(n_retry), 32'd0);

    // Long empty stretch: nothing may happen.
    nr = n_rinc; nv = n_valid;
    for (int i = 0; i < 50; i++) drive(0, 1, 0, 8'h11);
    chk("empty_rinc", 32'(n_rinc - nr), 32'd0);
    chk("empty_valid", 32'(n_valid - nv), 32'd0);

    // Ignored hand-off: retry after TO WAIT_ACK cycles, same word re-sent.
    nr = n_rinc; nv = n_valid; nt = n_retry; c0 = cyc;
    drive(0, 0, 0, 8'h5A);
    for (int i = 0; i < 18; i++) drive(0, 1, 0, '0);
    drive(0, 1, 1, '0);
    drive(0, 1, 1, '0);
    drive(0, 1, 0, '0);
    chk("retry_rinc", 32'(n_rinc - nr), 32'd1);
    chk("retry_valid", 32'(n_valid - nv), 32'd2);
    chk("retry_pulses", 32'(n_retry - nt), 32'd1);
    chk("retry_cycle", 32'(last_retry_cyc), 32'(c0 + 18));
    chk("retry_data", 32'(last_valid_data), 32'h5A);
    chk("retry_count", 32'(tx_count), 32'd4);

    // Acknowledge on the terminal timeout cycle wins over the retry.
    nt = n_retry;
    drive(0, 0, 0, 8'hC3);
    for (int i = 0; i < 16; i++) drive(0, 1, 0, '0);
    drive(0, 1, 1, '0);
    drive(0, 1, 0, '0);
    chk("ack_wins_retry", 32'(n_retry - nt), 32'd0);
    chk("ack_wins_count", 32'(tx_count), 32'd5);

    // External busy holds off the pop; pop lands in the cycle busy drops.
    nr = n_rinc;
    for (int i = 0; i < 20; i++) drive(0, 0, 1, 8'h77);
    chk("busy_hold_rinc", 32'(n_rinc - nr), 32'd0);
    c0 = cyc;
    drive(0, 0, 0, 8'h77);
    chk("busy_release_rinc", 32'(last_rinc_cyc), 32'(c0));
    drive(0, 1, 0, '0);
    drive(0, 1, 0, '0);
    drive(0, 1, 1, '0);
    drive(0, 1, 1, '0);

    // Reset while in WAIT_DONE, then the next word is drained normally.
    drive(1, 0, 1, 8'h88);
    chk("rst_count", 32'(tx_count), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    drive(0, 0, 0, 8'h88);
    drive(0, 1, 0, '0);
    chk("post_rst_data", 32'(tx_data), 32'h88);
    drive(0, 1, 0, '0);
    drive(0, 1, 1, '0);
    drive(0, 1, 0, '0);
    chk("post_rst_count", 32'(tx_count), 32'd1);

    // Counter wrap after 16 acknowledges.
    drive(1, 1, 0, '0);
    for (int i = 0; i < 15; i++) xfer_word(8'(i * 7 + 1));
    chk("wrap_pre", 32'(tx_count), 32'd15);
    xfer_word(8'hE1);
    chk("wrap_post", 32'(tx_count), 32'd0);

    // Randomized FIFO with lagging empty flag and an erratic transmitter.
    drive(1, 1, 0, '0);
    pop1 = 0; pop2 = 0; rise_at = 0; fall_at = 0; stale = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0 && q.size() < 8) q.push_back(8'($urandom_range(0, 255)));
      emp_eff = (q.size() == 0) && !pop1 && !pop2;
      dat = (q.size() != 0) ? q[0] : stale;
      if (!(cyc >= rise_at && cyc < fall_at) && cyc >= fall_at && $urandom_range(0, 19) == 0) begin
        rise_at = cyc;
        fall_at = cyc + $urandom_range(1, 3);
      end
      busy_r = (cyc >= rise_at && cyc < fall_at);
      c = cyc;
      drive(0, emp_eff, busy_r, dat);
      pop2 = pop1;
      pop1 = last_e_rinc;
      if (last_e_rinc && q.size() != 0) begin
        stale = q[0];
        void'(q.pop_front());
      end
      if (last_e_valid && $urandom_range(0, 7) != 0) begin
        rise_at = c + $urandom_range(1, 4);
        fall_at = rise_at + $urandom_range(1, 6);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
